// File: rtl/fetch_refill_ctrl_if.sv
// AXI4 read-address / read-data channel bundle for the fetch refill sequencer.
// The master modport is the sequencer side; the slave modport is the interconnect side.
interface fetch_refill_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              m_axi_arvalid_o;
    logic              m_axi_arready_i;
    logic [ADDR_W-1:0] m_axi_araddr_o;
    logic [7:0]        m_axi_arlen_o;
    logic [2:0]        m_axi_arsize_o;
    logic [1:0]        m_axi_arburst_o;
    logic              m_axi_rvalid_i;
    logic              m_axi_rready_o;
    logic [63:0]       m_axi_rdata_i;
    logic [1:0]        m_axi_rresp_i;
    logic              m_axi_rlast_i;

    modport master (
        output m_axi_arvalid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o,
               m_axi_arburst_o, m_axi_rready_o,
        input  m_axi_arready_i, m_axi_rvalid_i, m_axi_rdata_i, m_axi_rresp_i,
               m_axi_rlast_i
    );

    modport slave (
        input  m_axi_arvalid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o,
               m_axi_arburst_o, m_axi_rready_o,
        output m_axi_arready_i, m_axi_rvalid_i, m_axi_rdata_i, m_axi_rresp_i,
               m_axi_rlast_i
    );
endinterface

// File: rtl/fetch_refill_ctrl.sv
// Single-burst AXI4 INCR read sequencer streaming refill beats into the fetch CDC FIFO write port.
// Optional macro FETCH_REFILL_ERR_CHK_EN enables rresp/rlast checking and err_o reporting.
module fetch_refill_ctrl #(
    parameter int ADDR_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                axi_clk,
    input  logic                axi_resetn,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic                flush_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    fetch_refill_ctrl_if.master m_axi,
    output logic                fifo_wr_en_o,
    output logic [63:0]         fifo_wr_data_o,
    input  logic                fifo_wr_full_i
);

    localparam int               CNT_W    = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_drop;
    logic              r_flushed;
    logic              r_bad;
    logic              r_hold_vld;
    logic [63:0]       r_hold_data;
    logic              r_done;
    logic              r_err;

    logic              w_arvalid;
    logic              w_rready;
    logic              w_req_acc;
    logic              w_beat;
    logic              w_beat_bad;
    logic              w_load;
    logic              w_drain;
    logic              w_flush_act;
    logic              w_flush_data;
    logic              w_finish;
    logic              w_unused;

    assign w_req_acc    = (r_state == S_IDLE) & req_valid_i;
    assign w_flush_act  = (r_state != S_IDLE) & flush_i;
    assign w_flush_data = (r_state == S_DATA) & flush_i;
    assign w_drain      = r_hold_vld & ~fifo_wr_full_i;
    assign w_rready     = (r_state == S_DATA) & (r_cnt < LAST_CNT) &
                          (r_drop | ~r_hold_vld | ~fifo_wr_full_i);
    assign w_beat       = m_axi.m_axi_rvalid_i & w_rready;

`ifdef FETCH_REFILL_ERR_CHK_EN
    // A bad response or a misplaced/missing rlast poisons the rest of the burst.
    assign w_beat_bad = (m_axi.m_axi_rresp_i != 2'b00) |
                        (m_axi.m_axi_rlast_i != (r_cnt == LAST_IDX));
    assign w_unused   = ^req_addr_i[2:0];
`else
    assign w_beat_bad = 1'b0;
    assign w_unused   = ^{req_addr_i[2:0], m_axi.m_axi_rresp_i, m_axi.m_axi_rlast_i, LAST_IDX};
`endif

    assign w_load   = w_beat & ~r_drop & ~w_beat_bad & ~flush_i;
    // Burst is complete once every beat is in and the hold register is empty or emptying now.
    assign w_finish = (r_state == S_DATA) & (r_cnt == LAST_CNT) &
                      (~r_hold_vld | w_drain | flush_i);

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        w_arvalid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_arvalid = 1'b1;
                if (m_axi.m_axi_arready_i) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_finish) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            r_flushed   <= 1'b0;
            r_bad       <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_req_acc) begin
                r_addr    <= {req_addr_i[ADDR_W-1:3], 3'b000};
                r_cnt     <= '0;
                r_drop    <= 1'b0;
                r_flushed <= 1'b0;
                r_bad     <= 1'b0;
            end
            if (w_flush_act) begin
                r_drop    <= 1'b1;
                r_flushed <= 1'b1;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_beat_bad) begin
                    r_drop <= 1'b1;
                    r_bad  <= 1'b1;
                end
            end
            // A flush in DATA discards the held beat instead of writing it.
            if (w_flush_data) begin
                r_hold_vld <= 1'b0;
            end else if (w_load) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= m_axi.m_axi_rdata_i;
            end else if (w_drain) begin
                r_hold_vld <= 1'b0;
            end
            if (w_finish) begin
                r_done <= ~r_drop & ~flush_i;
                r_err  <= r_bad & ~r_flushed & ~flush_i;
            end
        end
    end

    assign m_axi.m_axi_arvalid_o = w_arvalid;
    assign m_axi.m_axi_araddr_o  = r_addr;
    assign m_axi.m_axi_arlen_o   = 8'(BEATS - 1);
    assign m_axi.m_axi_arsize_o  = 3'b011;
    assign m_axi.m_axi_arburst_o = 2'b01;
    assign m_axi.m_axi_rready_o  = w_rready;

    assign fifo_wr_en_o   = r_hold_vld;
    assign fifo_wr_data_o = r_hold_data;
    assign done_o         = r_done;
    assign err_o          = r_err;

endmodule

// File: tb/tb_fetch_refill_ctrl.sv
// Self-checking bench for fetch_refill_ctrl: directed vector table, reset sequences and
// randomized refills checked against a beat-level reference model.
module tb_fetch_refill_ctrl;
    localparam int ADDR_W = 64;
    localparam int BEATS  = 4;
`ifdef FETCH_REFILL_ERR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              axi_clk = 1'b0;
    logic              axi_resetn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              flush = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic              fifo_wr_en;
    logic [63:0]       fifo_wr_data;
    logic              fifo_full = 1'b0;

    fetch_refill_ctrl_if #(.ADDR_W(ADDR_W)) axi_if ();

    fetch_refill_ctrl #(.ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
        .axi_clk        (axi_clk),
        .axi_resetn     (axi_resetn),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .flush_i        (flush),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .m_axi          (axi_if),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .fifo_wr_full_i (fifo_full)
    );

    always #5 axi_clk = ~axi_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Slave / environment state
    logic [63:0] s_data [BEATS];
    logic [1:0]  s_resp [BEATS];
    logic        s_lastflip [BEATS];
    int          s_idx, ar_delay, ar_wait, rgap_pct, full_pct;
    int          full_after, full_len, full_cnt, flush_mode, flush_beat;
    bit          s_active, r_stall, full_armed, flush_done, req_pend;

    // Observations
    logic [63:0]       got_q[$];
    int                beat_cyc[$];
    int                n_done, n_err, n_ar, arv_cycles, n_rdy_viol, cyc;
    logic [ADDR_W-1:0] ar_addr_seen;
    logic [12:0]       ar_fields_seen;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] addr;
        int                ar_delay;
        int                full_after;
        int                full_len;
        int                flush_mode;
        int                flush_beat;
        int                err_beat;
        int                exp_nwr;
        bit                exp_done;
        bit                exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        check({tag, " busy"},      64'(busy), 64'd0);
        check({tag, " done"},      64'(done), 64'd0);
        check({tag, " err"},       64'(err), 64'd0);
        check({tag, " arvalid"},   64'(axi_if.m_axi_arvalid_o), 64'd0);
        check({tag, " araddr"},    axi_if.m_axi_araddr_o, 64'd0);
        check({tag, " rready"},    64'(axi_if.m_axi_rready_o), 64'd0);
        check({tag, " wr_en"},     64'(fifo_wr_en), 64'd0);
        check({tag, " wr_data"},   fifo_wr_data, 64'd0);
    endtask

    task automatic drive();
        if (axi_if.m_axi_arvalid_o) begin
            axi_if.m_axi_arready_i = (ar_wait >= ar_delay);
            ar_wait++;
        end else begin
            axi_if.m_axi_arready_i = 1'b0;
        end
        if (s_active && s_idx < BEATS && (r_stall || $urandom_range(99) >= 32'(rgap_pct))) begin
            axi_if.m_axi_rvalid_i = 1'b1;
            axi_if.m_axi_rdata_i  = s_data[s_idx];
            axi_if.m_axi_rresp_i  = s_resp[s_idx];
            axi_if.m_axi_rlast_i  = (s_idx == BEATS - 1) ^ s_lastflip[s_idx];
        end else begin
            axi_if.m_axi_rvalid_i = 1'b0;
            axi_if.m_axi_rdata_i  = '0;
            axi_if.m_axi_rresp_i  = 2'b00;
            axi_if.m_axi_rlast_i  = 1'b0;
        end
        if (full_cnt > 0) begin
            fifo_full = 1'b1;
            full_cnt--;
        end else begin
            fifo_full = (full_pct > 0) && ($urandom_range(99) < 32'(full_pct));
        end
        flush = 1'b0;
        if (!flush_done && flush_mode == 1 && axi_if.m_axi_arvalid_o) begin
            flush = 1'b1;
            flush_done = 1'b1;
        end else if (!flush_done && flush_mode == 2 && s_active && s_idx == flush_beat) begin
            flush = 1'b1;
            flush_done = 1'b1;
        end
        req_valid = req_pend;
    endtask

    task automatic sample();
        if (fifo_wr_en && !fifo_full) got_q.push_back(fifo_wr_data);
        if (done) n_done++;
        if (err) n_err++;
        if (fifo_wr_en && fifo_full && axi_if.m_axi_rready_o) n_rdy_viol++;
        if (axi_if.m_axi_arvalid_o) begin
            arv_cycles++;
            if (axi_if.m_axi_arready_i) begin
                n_ar++;
                ar_addr_seen   = axi_if.m_axi_araddr_o;
                ar_fields_seen = {axi_if.m_axi_arlen_o, axi_if.m_axi_arsize_o, axi_if.m_axi_arburst_o};
                s_active = 1'b1;
                s_idx    = 0;
            end
        end
        r_stall = axi_if.m_axi_rvalid_i && !axi_if.m_axi_rready_o;
        if (axi_if.m_axi_rvalid_i && axi_if.m_axi_rready_o) begin
            s_idx++;
            beat_cyc.push_back(cyc);
            if (s_idx == BEATS) s_active = 1'b0;
        end
        if (req_valid && req_ready) req_pend = 1'b0;
        if (full_after >= 0 && !full_armed && got_q.size() == full_after) begin
            full_cnt   = full_len;
            full_armed = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge axi_clk);
        drive();
        #1;
        sample();
        cyc++;
    endtask

    task automatic clear_obs();
        got_q.delete();
        beat_cyc.delete();
        n_done = 0; n_err = 0; n_ar = 0; arv_cycles = 0; n_rdy_viol = 0;
        ar_wait = 0; flush_done = 1'b0; full_armed = 1'b0; full_cnt = 0;
        s_active = 1'b0; s_idx = 0; r_stall = 1'b0;
    endtask

    // Reference model: which beats reach the FIFO and how the refill ends.
    task automatic model(output int nwr, output bit exp_done, output bit exp_err);
        bit bad = 1'b0;
        nwr = BEATS;
        for (int i = BEATS - 1; i >= 0; i--)
            if (s_resp[i] != 2'b00 || s_lastflip[i]) begin
                bad = 1'b1;
                if (CHK) nwr = i;
            end
        if (flush_mode != 0) nwr = 0;
        exp_done = (flush_mode == 0) && !(CHK && bad);
        exp_err  = (flush_mode == 0) && CHK && bad;
    endtask

    task automatic run_refill(input string tag, input logic [ADDR_W-1:0] addr,
                              input int exp_nwr, input bit exp_done, input bit exp_err);
        int t;
        bit seen;
        clear_obs();
        req_addr = addr;
        req_pend = 1'b1;
        t = 0;
        seen = 1'b0;
        while (t < 400) begin
            cycle();
            t++;
            if (seen && !busy) break;
            if (!req_pend) seen = 1'b1;
        end
        check({tag, " timeout"}, 64'(t < 400), 64'd1);
        cycle();
        cycle();
        check({tag, " araddr"}, ar_addr_seen, {addr[ADDR_W-1:3], 3'b000});
        check({tag, " ar_fields"}, 64'(ar_fields_seen), 64'({8'(BEATS - 1), 3'b011, 2'b01}));
        check({tag, " ar_count"}, 64'(n_ar), 64'd1);
        check({tag, " arvalid_cycles"}, 64'(arv_cycles), 64'(ar_delay + 1));
        check({tag, " beats_accepted"}, 64'(beat_cyc.size()), 64'(BEATS));
        check({tag, " fifo_writes"}, 64'(got_q.size()), 64'(exp_nwr));
        for (int i = 0; i < exp_nwr && i < got_q.size(); i++)
            check($sformatf("%s wr_data[%0d]", tag, i), got_q[i], s_data[i]);
        check({tag, " done_pulses"}, 64'(n_done), 64'(exp_done));
        check({tag, " err_pulses"}, 64'(n_err), 64'(exp_err));
        if (exp_done) check({tag, " rready_while_full"}, 64'(n_rdy_viol), 64'd0);
        if (flush_mode == 2 && beat_cyc.size() == BEATS)
            check({tag, " drain_rate"}, 64'(beat_cyc[BEATS-1] - beat_cyc[1]), 64'(BEATS - 2));
    endtask

    task automatic setup_beats(input int err_beat);
        for (int i = 0; i < BEATS; i++) begin
            s_data[i]     = {$urandom, $urandom};
            s_resp[i]     = 2'b00;
            s_lastflip[i] = 1'b0;
        end
        if (err_beat >= 0) s_resp[err_beat] = 2'b10;
    endtask

    initial begin
        int nwr;
        bit ed, ee;
        axi_if.m_axi_arready_i = 1'b0;
        axi_if.m_axi_rvalid_i  = 1'b0;
        axi_if.m_axi_rdata_i   = '0;
        axi_if.m_axi_rresp_i   = 2'b00;
        axi_if.m_axi_rlast_i   = 1'b0;
        cyc = 0; rgap_pct = 0; full_pct = 0; full_after = -1; full_len = 0;
        flush_mode = 0; flush_beat = 0; ar_delay = 0; req_pend = 1'b0;
        clear_obs();

        tbl[0] = '{"basic",       64'h0000_0000_8000_1234, 0, -1,  0, 0, 0, -1, 4, 1'b1, 1'b0};
        tbl[1] = '{"backpress",   64'h0000_0000_8000_2000, 1,  2,  5, 0, 0, -1, 4, 1'b1, 1'b0};
        tbl[2] = '{"flush_addr",  64'h0000_0000_8000_3008, 3, -1,  0, 1, 0, -1, 0, 1'b0, 1'b0};
        tbl[3] = '{"flush_data",  64'h0000_0000_8000_4017, 0,  0, 40, 2, 1, -1, 0, 1'b0, 1'b0};
        tbl[4] = '{"after_flush", 64'h0000_0000_8000_5018, 0, -1,  0, 0, 0, -1, 4, 1'b1, 1'b0};
        tbl[5] = '{"slverr_b2",   64'h0000_0000_8000_6020, 0, -1,  0, 0, 0,  1,
                   CHK ? 1 : 4, !CHK, CHK};

        #12;
        check_reset("reset");
        @(negedge axi_clk);
        axi_resetn = 1'b1;

        foreach (tbl[v]) begin
            ar_delay   = tbl[v].ar_delay;
            full_after = tbl[v].full_after;
            full_len   = tbl[v].full_len;
            flush_mode = tbl[v].flush_mode;
            flush_beat = tbl[v].flush_beat;
            setup_beats(tbl[v].err_beat);
            run_refill(tbl[v].name, tbl[v].addr, tbl[v].exp_nwr, tbl[v].exp_done, tbl[v].exp_err);
        end

        // Asynchronous reset in the middle of a burst, then a clean refill.
        ar_delay = 0; full_after = -1; full_len = 0; flush_mode = 0;
        setup_beats(-1);
        clear_obs();
        req_addr = 64'h0000_0000_8000_7000;
        req_pend = 1'b1;
        for (int t = 0; t < 50 && s_idx < 2; t++) cycle();
        check("rst_mid reached_data", 64'(s_idx), 64'd2);
        axi_resetn = 1'b0;
        #1;
        check_reset("rst_mid");
        req_pend = 1'b0; req_valid = 1'b0; flush = 1'b0; fifo_full = 1'b0;
        axi_if.m_axi_arready_i = 1'b0;
        axi_if.m_axi_rvalid_i  = 1'b0;
        clear_obs();
        @(negedge axi_clk);
        axi_resetn = 1'b1;
        setup_beats(-1);
        run_refill("post_reset", 64'h0000_0000_8000_7040, 4, 1'b1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            ar_delay   = $urandom_range(3);
            rgap_pct   = $urandom_range(40);
            full_pct   = $urandom_range(50);
            full_after = -1;
            full_len   = 0;
            flush_mode = ($urandom_range(7) == 0) ? 1 : 0;
            setup_beats(-1);
            if ($urandom_range(3) == 0) s_resp[$urandom_range(BEATS - 1)] = 2'($urandom_range(3, 1));
            if ($urandom_range(5) == 0) s_lastflip[$urandom_range(BEATS - 1)] = 1'b1;
            model(nwr, ed, ee);
            run_refill($sformatf("rand%0d", k), {$urandom, $urandom}, nwr, ed, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_refill_ctrl.md
# fetch_refill_ctrl

Single-burst AXI4 read sequencer on the fetch path's AXI-clock side. It accepts a line-refill request, issues one INCR read burst, and streams the returned 64-bit beats into the write port of the fetch clock-crossing FIFO. It honours FIFO backpressure, supports flushing a refill in flight, and reports completion. The FIFO read side and the CPU clock domain are outside this block.

## Interface
Parameters:
- ADDR_W, 64, AXI address width
- BEATS, 4, beats per refill burst (power of two, 1..16); arlen = BEATS-1

Ports (name, direction, width, meaning):
- axi_clk  in  1  the block's only clock
- axi_resetn  in  1  asynchronous, active-low reset
- req_valid_i  in  1  refill request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_addr_i  in  ADDR_W  line address; bits [2:0] are ignored
- flush_i  in  1  abandon the current refill
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse when a refill has fully reached the FIFO
- err_o  out  1  one-cycle pulse when a refill fails (see Configuration)
- m_axi_arvalid_o / m_axi_arready_i  out/in  1  AR handshake
- m_axi_araddr_o  out  ADDR_W  burst address, bits [2:0] = 0
- m_axi_arlen_o  out  8  constant BEATS-1
- m_axi_arsize_o  out  3  constant 3'b011
- m_axi_arburst_o  out  2  constant 2'b01 (INCR)
- m_axi_rvalid_i / m_axi_rready_o  in/out  1  R handshake
- m_axi_rdata_i  in  64  beat data
- m_axi_rresp_i  in  2  beat response
- m_axi_rlast_i  in  1  last beat marker
- fifo_wr_en_o  out  1  FIFO write strobe
- fifo_wr_data_o  out  64  FIFO write data
- fifo_wr_full_i  in  1  FIFO full

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: req_ready_o = 1. On req_valid_i, register the address with [2:0] cleared, clear the beat counter and drop flag, and go to ADDR.
- ADDR: m_axi_arvalid_o = 1, araddr held stable. On m_axi_arready_i, go to DATA.
- DATA: each accepted R beat increments the beat counter, which is clog2(BEATS)+1 bits wide.
  - If drop = 0, the beat is loaded into a one-entry hold register.
  - If drop = 1, the beat is discarded.
  - After beat BEATS is accepted, return to IDLE once the hold register is empty.
- Hold register drives the FIFO: fifo_wr_en_o = hold_valid and fifo_wr_data_o = hold_data. The register clears when hold_valid is set and fifo_wr_full_i is low.
- m_axi_rready_o = (state == DATA) & (beat count < BEATS) & (drop | ~hold_valid | ~fifo_wr_full_i).
- Completion:
  - done_o pulses on the cycle the last hold entry drains, provided drop = 0.
  - A dropped burst never pulses done_o.
- Flush (flush_i = 1):
  - IDLE: no effect.
  - ADDR: set drop. arvalid stays asserted until the handshake completes (AXI rule), then DATA drains the burst.
  - DATA: set drop and clear hold_valid the same cycle (the held beat is not written). Remaining beats are accepted at one per cycle and discarded.
- A request is never accepted while busy. A flush and a new request in the same IDLE cycle accept the request.

## Timing
- Reset (async assert, sync deassert by the system) sets the following:
  - state = IDLE; req_ready_o = 1 and every other output = 0.
  - Counters, drop, hold_valid = 0.
  - An in-flight burst is abandoned; the interconnect is reset alongside this block.
- Request handshake at edge N: arvalid is high from N+1.
- AR handshake at edge M: rready can be high from M+1.
- R beat accepted at edge K: fifo_wr_en_o is high from K+1.
- Full throughput: one beat per cycle while the FIFO is not full.
- Back-to-back refills: minimum 2 idle-side cycles between bursts (DATA→IDLE, IDLE→ADDR).
- done_o / err_o: asserted the cycle after the final FIFO write or drop completes, for exactly one cycle.

## Configuration
- FETCH_REFILL_ERR_CHK_EN defined (checking on):
  - A beat with rresp ≠ 2'b00 sets drop, and that beat is discarded.
  - rlast asserted on a beat other than beat BEATS, or missing on beat BEATS, also sets drop.
  - The burst then drains to beat count BEATS.
  - err_o pulses instead of done_o. A flush-induced drop never pulses err_o.
- Undefined (checking off):
  - rresp and rlast are ignored, and the burst ends on the beat count alone.
  - err_o is tied to 0.

## Test plan
- Request addr 0x8000_1234, BEATS=4, slave returns 4 OKAY beats with no backpressure:
  - araddr = 0x8000_1230, arlen = 3, arsize = 3, arburst = 1.
  - 4 consecutive fifo_wr_en_o cycles carry the data in order.
  - done_o pulses once; busy_o falls.
- fifo_wr_full_i held high for 5 cycles after beat 2 is written: rready is low while the hold register is full, no beat is lost or duplicated, and all 4 beats arrive in order with done_o = 1.
- flush_i during ADDR with arready delayed 3 cycles: arvalid stays high until the handshake, all 4 beats are accepted with zero FIFO writes, and done_o = err_o = 0 with a return to IDLE.
- flush_i in DATA after beat 1 while the FIFO is full: the held beat is never written, the remaining 3 beats are accepted one per cycle, and a new request is accepted afterwards.
- With FETCH_REFILL_ERR_CHK_EN, rresp = SLVERR on beat 2: only beat 1 is written and err_o pulses once. The same stimulus without the macro writes 4 beats and pulses done_o.
- axi_resetn asserted mid-DATA: all outputs go to reset values immediately, and the next request runs normally.
